// File: rtl/uart_pkg.sv
// Shared definitions for the strobed UART transmitter: FSM encoding, parity modes
// and the frame length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Number of baud strobes from the start of the start bit to the end of the last stop bit
    function automatic int frame_bits(int data_width, int parity, int stop_bits);
        return 1 + data_width + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_strobed_if.sv
// Valid/ready word handshake between an upstream producer and the UART transmitter.
interface uart_tx_strobed_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_shift.sv
// Loadable right-shift register feeding the serial line LSB first, with the parity
// bit captured from the word at load time.
module uart_tx_shift
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = PARITY_NONE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ser_bit,
    output logic                  par_bit
);

    logic [DATA_WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            par_bit <= 1'b0;
        end else if (load) begin
            sr      <= din;
            par_bit <= (PARITY == PARITY_ODD) ? ~^din : ^din;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign ser_bit = sr[0];

endmodule

// File: rtl/uart_tx_strobed.sv
// UART transmitter paced by an external baud strobe; it owns the strobe counter's
// enable/restart so every frame begins on a full bit period.
module uart_tx_strobed
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    baud_strobe,
    output logic                    baud_enable,
    output logic                    baud_restart,
    uart_tx_strobed_if.slave        src,
    output logic                    tx,
    output logic                    busy,
    output logic                    frame_done
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 16 || PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_tx_strobed: parameter out of range");
    end

    localparam int              CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    uart_state_e      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       stop_cnt;
    logic             ready_q;
    logic             load;
    logic             shift;
    logic             strobe_ok;
    logic             ser_bit;
    logic             par_bit;

    // The counter restarts on baud_restart, so a strobe in that same cycle belongs to the old count
    assign strobe_ok      = baud_strobe && !baud_restart;
    assign load           = (state == IDLE) && src.data_valid && ready_q;
    assign shift          = strobe_ok && ((state == START) || (state == DATA));
    assign src.data_ready = ready_q;

    uart_tx_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .PARITY     (PARITY)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .din     (src.data_in),
        .ser_bit (ser_bit),
        .par_bit (par_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            stop_cnt     <= '0;
            ready_q      <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            baud_enable  <= 1'b0;
            baud_restart <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            baud_restart <= 1'b0;
            frame_done   <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (load) begin
                        state        <= START;
                        ready_q      <= 1'b0;
                        tx           <= 1'b0;
                        busy         <= 1'b1;
                        baud_enable  <= 1'b1;
                        baud_restart <= 1'b1;
                        bit_cnt      <= '0;
                        stop_cnt     <= '0;
                    end
                end
                START: begin
                    if (strobe_ok) begin
                        state <= DATA;
                        tx    <= ser_bit;
                    end
                end
                DATA: begin
                    if (strobe_ok) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY != PARITY_NONE) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx <= ser_bit;
                        end
                    end
                end
                PAR: begin
                    if (strobe_ok) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (strobe_ok) begin
                        if (stop_cnt == LAST_STOP) begin
                            state       <= IDLE;
                            frame_done  <= 1'b1;
                            busy        <= 1'b0;
                            baud_enable <= 1'b0;
                            ready_q     <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_strobed.sv
// Bench for uart_tx_strobed: three parity/stop variants share one stimulus stream and
// a scoreboard of expected line bits, each paced by a behavioural strobe counter.
module tb_uart_tx_strobed;
    import uart_pkg::*;

    localparam int N  = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          strobe       [N];
    logic          force_strobe [N];
    logic          en           [N];
    logic          restart      [N];
    logic          tx           [N];
    logic          busy         [N];
    logic          done         [N];
    logic          vld          [N];
    logic          rdy          [N];
    logic [DW-1:0] din          [N];
    logic [1:0]    bcnt         [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int P = (g == 0) ? PARITY_NONE : (g == 1) ? PARITY_ODD : PARITY_EVEN;
        localparam int S = (g == 1) ? 2 : 1;

        uart_tx_strobed_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.data_in    = din[g];
        assign bus.data_valid = vld[g];
        assign rdy[g]         = bus.data_ready;

        // Divide-by-4 strobe counter: cleared while disabled or on restart
        always @(posedge clk) begin
            if (en[g] !== 1'b1 || restart[g] === 1'b1) bcnt[g] <= 2'd0;
            else                                       bcnt[g] <= bcnt[g] + 2'd1;
        end
        assign strobe[g] = ((en[g] === 1'b1) && (bcnt[g] == 2'd3)) || force_strobe[g];

        uart_tx_strobed #(
            .DATA_WIDTH (DW),
            .PARITY     (P),
            .STOP_BITS  (S)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .baud_strobe  (strobe[g]),
            .baud_enable  (en[g]),
            .baud_restart (restart[g]),
            .src          (bus),
            .tx           (tx[g]),
            .busy         (busy[g]),
            .frame_done   (done[g])
        );
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] stim [$];
    logic          eq0 [$];
    logic          eq1 [$];
    logic          eq2 [$];
    int            sidx        [N];
    int            accepts     [N];
    int            restarts    [N];
    int            frames_done [N];
    int            dropped     [N];
    int            strb_cnt    [N];
    int            restart_cyc [N];
    int            done_cyc    [N];
    bit            b2b         [N];
    bit            force_on_restart = 1'b0;

    function automatic int par_of(int g);
        return (g == 0) ? PARITY_NONE : (g == 1) ? PARITY_ODD : PARITY_EVEN;
    endfunction

    function automatic int stop_of(int g);
        return (g == 1) ? 2 : 1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(int g, logic [DW-1:0] w);
        logic b [$];
        b.push_back(1'b0);
        for (int i = 0; i < DW; i++) b.push_back(w[i]);
        if (par_of(g) == PARITY_ODD)  b.push_back(~^w);
        if (par_of(g) == PARITY_EVEN) b.push_back(^w);
        for (int i = 0; i < stop_of(g); i++) b.push_back(1'b1);
        foreach (b[i]) begin
            case (g)
                0:       eq0.push_back(b[i]);
                1:       eq1.push_back(b[i]);
                default: eq2.push_back(b[i]);
            endcase
        end
    endtask

    task automatic pop_exp(int g, output logic b, output bit ok);
        ok = 1'b1;
        b  = 1'bx;
        case (g)
            0:       if (eq0.size() > 0) b = eq0.pop_front(); else ok = 1'b0;
            1:       if (eq1.size() > 0) b = eq1.pop_front(); else ok = 1'b0;
            default: if (eq2.size() > 0) b = eq2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int exp_size(int g);
        return (g == 0) ? eq0.size() : (g == 1) ? eq1.size() : eq2.size();
    endfunction

    task automatic drive_inputs();
        for (int g = 0; g < N; g++) begin
            if (sidx[g] < stim.size()) begin
                vld[g] = 1'b1;
                din[g] = stim[sidx[g]];
            end else begin
                vld[g] = 1'b0;
                din[g] = DW'($urandom);
            end
        end
    endtask

    task automatic monitor();
        logic b;
        bit   ok;
        for (int g = 0; g < N; g++) begin
            if (restart[g] === 1'b1) begin
                check($sformatf("start_tx_low[%0d]", g), 32'(tx[g]), 32'd0);
                check($sformatf("start_busy[%0d]", g), 32'(busy[g]), 32'd1);
                if (b2b[g]) begin
                    check($sformatf("b2b_gap[%0d]", g), cyc - done_cyc[g], 32'd1);
                    b2b[g] = 1'b0;
                end
                restarts[g]++;
                restart_cyc[g] = cyc;
                strb_cnt[g]    = 0;
            end
            if (strobe[g] === 1'b1 && busy[g] === 1'b1 && restart[g] !== 1'b1) begin
                strb_cnt[g]++;
                if (strb_cnt[g] == 1)
                    check($sformatf("start_len[%0d]", g), cyc - restart_cyc[g], 32'd4);
                pop_exp(g, b, ok);
                check($sformatf("exp_avail[%0d]", g), 32'(ok), 32'd1);
                if (ok) check($sformatf("tx_bit[%0d] n=%0d", g, strb_cnt[g]), 32'(tx[g]), 32'(b));
            end
            if (done[g] === 1'b1) begin
                check($sformatf("done_len[%0d]", g), strb_cnt[g],
                      frame_bits(DW, par_of(g), stop_of(g)));
                check($sformatf("done_ready[%0d]", g), 32'(rdy[g]), 32'd1);
                check($sformatf("done_busy[%0d]", g), 32'(busy[g]), 32'd0);
                check($sformatf("done_en[%0d]", g), 32'(en[g]), 32'd0);
                check($sformatf("done_q_empty[%0d]", g), exp_size(g), 32'd0);
                frames_done[g]++;
                done_cyc[g] = cyc;
                b2b[g]      = (vld[g] === 1'b1);
            end
        end
    endtask

    task automatic step();
        bit acc [N];
        for (int g = 0; g < N; g++) acc[g] = (vld[g] === 1'b1) && (rdy[g] === 1'b1) && !rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < N; g++) begin
            force_strobe[g] = acc[g] && force_on_restart;
            if (acc[g]) begin
                push_frame(g, din[g]);
                sidx[g]++;
                accepts[g]++;
            end
        end
        drive_inputs();
        @(negedge clk);
        monitor();
    endtask

    function automatic bit all_idle();
        for (int g = 0; g < N; g++)
            if (sidx[g] < stim.size() || busy[g] !== 1'b0 || rdy[g] !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_idle(string tag, int max_cycles);
        int n;
        bit idle;
        n = 0;
        do begin
            step();
            n++;
            idle = all_idle();
        end while (!idle && n < max_cycles);
        check({tag, "_completes"}, 32'(idle), 32'd1);
    endtask

    task automatic check_idle_outputs(string tag);
        for (int g = 0; g < N; g++) begin
            check($sformatf("%s_tx[%0d]", tag, g), 32'(tx[g]), 32'd1);
            check($sformatf("%s_busy[%0d]", tag, g), 32'(busy[g]), 32'd0);
            check($sformatf("%s_ready[%0d]", tag, g), 32'(rdy[g]), 32'd1);
            check($sformatf("%s_en[%0d]", tag, g), 32'(en[g]), 32'd0);
        end
    endtask

    initial begin
        int n;
        for (int g = 0; g < N; g++) begin
            vld[g] = 1'b0; din[g] = '0; force_strobe[g] = 1'b0;
            sidx[g] = 0; accepts[g] = 0; restarts[g] = 0; frames_done[g] = 0;
            dropped[g] = 0; strb_cnt[g] = 0; restart_cyc[g] = 0; done_cyc[g] = 0; b2b[g] = 1'b0;
        end

        // Reset state
        step();
        step();
        for (int g = 0; g < N; g++) begin
            check($sformatf("rst_tx[%0d]", g), 32'(tx[g]), 32'd1);
            check($sformatf("rst_busy[%0d]", g), 32'(busy[g]), 32'd0);
            check($sformatf("rst_ready[%0d]", g), 32'(rdy[g]), 32'd0);
            check($sformatf("rst_en[%0d]", g), 32'(en[g]), 32'd0);
            check($sformatf("rst_restart[%0d]", g), 32'(restart[g]), 32'd0);
            check($sformatf("rst_done[%0d]", g), 32'(done[g]), 32'd0);
        end
        rst = 1'b0;
        for (int g = 0; g < N; g++) check($sformatf("ready_before_clk[%0d]", g), 32'(rdy[g]), 32'd0);
        step();
        check_idle_outputs("release");

        // Spurious strobe while idle
        for (int g = 0; g < N; g++) force_strobe[g] = 1'b1;
        step();
        step();
        check_idle_outputs("idle_strobe");

        // 0xA5 with a strobe coincident with the restart pulse
        force_on_restart = 1'b1;
        stim.push_back(8'hA5);
        drive_inputs();
        run_until_idle("a5", 400);
        force_on_restart = 1'b0;

        stim.push_back(8'h01);
        drive_inputs();
        run_until_idle("w01", 400);

        // Back-to-back with data_valid held
        stim.push_back(8'h00);
        stim.push_back(8'hFF);
        drive_inputs();
        run_until_idle("b2b", 400);

        // Reset in the middle of the data bits
        stim.push_back(8'h3C);
        drive_inputs();
        n = 0;
        do begin
            step();
            n++;
        end while (strb_cnt[0] < 3 && n < 100);
        check("reach_data", 32'(strb_cnt[0] >= 3), 32'd1);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < N; g++) begin
            check($sformatf("midrst_tx[%0d]", g), 32'(tx[g]), 32'd1);
            check($sformatf("midrst_busy[%0d]", g), 32'(busy[g]), 32'd0);
            check($sformatf("midrst_en[%0d]", g), 32'(en[g]), 32'd0);
            dropped[g]  = accepts[g] - frames_done[g];
            strb_cnt[g] = 0;
            b2b[g]      = 1'b0;
        end
        eq0.delete();
        eq1.delete();
        eq2.delete();
        for (int k = 0; k < 3; k++) begin
            step();
            for (int g = 0; g < N; g++) check($sformatf("midrst_no_done[%0d]", g), 32'(done[g]), 32'd0);
        end
        rst = 1'b0;
        step();
        check_idle_outputs("rerelease");

        stim.push_back(8'h5A);
        drive_inputs();
        run_until_idle("w5a", 400);

        // Every word accepted once, one restart per accepted word, one done per completed frame
        for (int g = 0; g < N; g++) begin
            check($sformatf("accepts[%0d]", g), accepts[g], 32'd6);
            check($sformatf("dropped[%0d]", g), dropped[g], 32'd1);
            check($sformatf("restarts[%0d]", g), restarts[g], accepts[g]);
            check($sformatf("frames_done[%0d]", g), frames_done[g], 32'd5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
